// File: rtl/stream_demux_1ton.sv
// ---------------------------------------------------------------------------
// stream_demux_1ton
//
// Registered 1:N stream demultiplexer with valid/ready handshakes and
// packet-locked routing. The destination of a packet is chosen on its first
// beat (explicit in_sel in mode 0, round-robin pointer in mode 1) and held
// until the beat carrying in_last is accepted. Every output channel owns a
// single-entry register, so an accepted beat shows up one cycle later and a
// channel can sustain one beat per cycle while its consumer keeps up.
// Packets addressed to a channel that does not exist are swallowed and
// flagged on drop_err, one pulse per beat.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   mode       0 = explicit select, 1 = round-robin per packet
//   in_valid   upstream beat valid
//   in_ready   upstream beat accepted when in_valid && in_ready
//   in_data    beat payload, DATA_W bits
//   in_last    final beat of a packet
//   in_sel     destination channel (mode 0, first beat only)
//   out_valid  per-channel valid, NUM_OUT bits
//   out_ready  per-channel consumer ready, NUM_OUT bits
//   out_data   channel k payload at [k*DATA_W +: DATA_W]
//   out_last   per-channel last flag
//   drop_err   one-cycle pulse per dropped beat
//   rr_ptr     current round-robin pointer (debug)
// ---------------------------------------------------------------------------
module stream_demux_1ton #(
    parameter int DATA_W  = 8,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        mode,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_last,
    input  logic [SEL_W-1:0]            in_sel,
    output logic [NUM_OUT-1:0]          out_valid,
    input  logic [NUM_OUT-1:0]          out_ready,
    output logic [NUM_OUT*DATA_W-1:0]   out_data,
    output logic [NUM_OUT-1:0]          out_last,
    output logic                        drop_err,
    output logic [SEL_W-1:0]            rr_ptr
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // One extra bit so the illegal-select compare also works when
    // NUM_OUT == 2**SEL_W (then no select value is illegal).
    localparam logic [SEL_W:0]   NUM_OUT_EXT = (SEL_W + 1)'(NUM_OUT);
    localparam logic [SEL_W-1:0] LAST_CH     = SEL_W'(NUM_OUT - 1);

    state_t               state;
    state_t               state_next;
    logic [SEL_W-1:0]     dest_q;
    logic                 drop_q;
    logic                 mode_q;
    logic                 run_en;

    logic [SEL_W-1:0]     cur_dest;
    logic                 cur_drop;
    logic                 cur_mode;
    logic                 dest_free;
    logic                 accept;
    logic [NUM_OUT-1:0]   chan_free;
    logic [NUM_OUT-1:0]   chan_write;

    // Routing decision for the beat currently offered. In IDLE it comes
    // straight from the inputs; once locked, the captured packet context is
    // used so later in_sel / mode changes have no effect.
    always_comb begin
        cur_dest = dest_q;
        cur_drop = drop_q;
        cur_mode = mode_q;
        if (state == IDLE) begin
            cur_mode = mode;
            if (mode) begin
                cur_dest = rr_ptr;
                cur_drop = 1'b0;
            end else begin
                cur_dest = in_sel;
                cur_drop = ({1'b0, in_sel} >= NUM_OUT_EXT);
            end
        end
    end

    // A channel can take a new beat if it is empty or is being drained this
    // cycle. Only the destination channel's state gates the upstream.
    always_comb begin
        chan_free = ~out_valid | out_ready;
        dest_free = 1'b0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (cur_dest == SEL_W'(k)) begin
                dest_free = chan_free[k];
            end
        end
    end

    // Dropped packets are always accepted so the upstream never stalls on
    // them; run_en keeps the input closed while reset is asserted.
    assign in_ready = run_en & (cur_drop | dest_free);
    assign accept   = in_valid & in_ready;

    always_comb begin
        chan_write = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            chan_write[k] = accept & ~cur_drop & (cur_dest == SEL_W'(k));
        end
    end

    // run_en clears asynchronously and sets on the first clock after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_en <= 1'b0;
        end else begin
            run_en <= 1'b1;
        end
    end

    // Per-channel output registers. A write wins over a drain, so a beat
    // arriving while the old one leaves simply replaces it and out_valid
    // stays high. With out_ready low and no write, everything holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_data  <= '0;
            out_last  <= '0;
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (chan_write[k]) begin
                    out_valid[k]                   <= 1'b1;
                    out_data[k*DATA_W +: DATA_W]   <= in_data;
                    out_last[k]                    <= in_last;
                end else if (out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
        end
    end

    // Error pulse lands the cycle after each swallowed beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_err <= 1'b0;
        end else begin
            drop_err <= accept & cur_drop;
        end
    end

    // Round-robin pointer advances on the last beat of a mode-1 packet,
    // using the mode captured at packet start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept && in_last && cur_mode) begin
            rr_ptr <= (rr_ptr == LAST_CH) ? '0 : rr_ptr + 1'b1;
        end
    end

    // Packet context captured on the first accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dest_q <= '0;
            drop_q <= 1'b0;
            mode_q <= 1'b0;
        end else if (state == IDLE && accept) begin
            dest_q <= cur_dest;
            drop_q <= cur_drop;
            mode_q <= cur_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && !in_last) begin
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (accept && in_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_stream_demux_1ton.sv
// ---------------------------------------------------------------------------
// tb_stream_demux_1ton
//
// Bench for stream_demux_1ton. Two instances: dut_a with four channels
// (routing, backpressure, round-robin, reset) and dut_b with three channels
// so that in_sel = 3 is an illegal destination. Stimulus pushes the expected
// beat for each accepted input into a scoreboard; a monitor pops and compares
// whenever a channel completes a handshake.
// ---------------------------------------------------------------------------
module tb_stream_demux_1ton;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        mode_a;
    logic        in_valid_a;
    logic        in_ready_a;
    logic [7:0]  in_data_a;
    logic        in_last_a;
    logic [1:0]  in_sel_a;
    logic [3:0]  out_valid_a;
    logic [3:0]  out_ready_a;
    logic [31:0] out_data_a;
    logic [3:0]  out_last_a;
    logic        drop_err_a;
    logic [1:0]  rr_ptr_a;

    logic        mode_b;
    logic        in_valid_b;
    logic        in_ready_b;
    logic [7:0]  in_data_b;
    logic        in_last_b;
    logic [1:0]  in_sel_b;
    logic [2:0]  out_valid_b;
    logic [2:0]  out_ready_b;
    logic [23:0] out_data_b;
    logic [2:0]  out_last_b;
    logic        drop_err_b;
    logic [1:0]  rr_ptr_b;

    typedef struct {
        int         chan;
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t sb[$];
    int   checks     = 0;
    int   errors     = 0;
    int   seen_drops = 0;

    always #5 clk = ~clk;

    stream_demux_1ton #(.DATA_W(8), .NUM_OUT(4), .SEL_W(2)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode_a),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .in_data   (in_data_a),
        .in_last   (in_last_a),
        .in_sel    (in_sel_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready_a),
        .out_data  (out_data_a),
        .out_last  (out_last_a),
        .drop_err  (drop_err_a),
        .rr_ptr    (rr_ptr_a)
    );

    stream_demux_1ton #(.DATA_W(8), .NUM_OUT(3), .SEL_W(2)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode_b),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .in_data   (in_data_b),
        .in_last   (in_last_b),
        .in_sel    (in_sel_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .out_data  (out_data_b),
        .out_last  (out_last_b),
        .drop_err  (drop_err_b),
        .rr_ptr    (rr_ptr_b)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Compare a completed output handshake against the oldest expected beat
    // for that channel (scoreboard channels 0..3 = dut_a, 4..6 = dut_b).
    task automatic checkBeat(input int chan, input logic [7:0] data, input logic last);
        int idx;
        idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].chan == chan) begin
                idx = i;
                break;
            end
        end
        checks++;
        if (idx < 0) begin
            errors++;
            $display("[TB] FAIL beat_ch%0d: got data=%h last=%b, expected no beat", chan, data, last);
        end else begin
            if (sb[idx].data !== data || sb[idx].last !== last) begin
                errors++;
                $display("[TB] FAIL beat_ch%0d: got data=%h last=%b, expected data=%h last=%b",
                         chan, data, last, sb[idx].data, sb[idx].last);
            end
            sb.delete(idx);
        end
    endtask

    // Monitor: sampled on the falling edge, where inputs and outputs are
    // stable ahead of the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid_a[k] && out_ready_a[k]) begin
                    checkBeat(k, out_data_a[k*8 +: 8], out_last_a[k]);
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (out_valid_b[k] && out_ready_b[k]) begin
                    checkBeat(4 + k, out_data_b[k*8 +: 8], out_last_b[k]);
                end
            end
            if (drop_err_a) seen_drops++;
            if (drop_err_b) seen_drops++;
        end
    end

    // Offer one beat and wait (bounded) for it to be accepted. exp_chan is
    // the channel it must emerge on; -1 means dropped, -2 means it will be
    // discarded by a reset before it can leave.
    task automatic applyStimulus(input int which, input logic [1:0] sel,
                                 input logic [7:0] data, input logic last,
                                 input int exp_chan);
        int   waited;
        logic rdy;
        exp_t e;
        if (which == 0) begin
            in_valid_a = 1'b1;
            in_sel_a   = sel;
            in_data_a  = data;
            in_last_a  = last;
        end else begin
            in_valid_b = 1'b1;
            in_sel_b   = sel;
            in_data_b  = data;
            in_last_b  = last;
        end
        waited = 0;
        @(negedge clk);
        rdy = (which == 0) ? in_ready_a : in_ready_b;
        while (!rdy && waited < 40) begin
            waited++;
            @(negedge clk);
            rdy = (which == 0) ? in_ready_a : in_ready_b;
        end
        if (!rdy) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: in_ready got 0 for %0d cycles, expected 1", waited);
        end else if (exp_chan >= 0) begin
            e.chan = (which == 0) ? exp_chan : 4 + exp_chan;
            e.data = data;
            e.last = last;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleInput(input int which);
        if (which == 0) in_valid_a = 1'b0;
        else            in_valid_b = 1'b0;
    endtask

    initial begin
        int         waited;
        logic [1:0] s;
        logic [7:0] d;

        rst_n       = 1'b0;
        mode_a      = 1'b0;
        in_valid_a  = 1'b0;
        in_data_a   = '0;
        in_last_a   = 1'b0;
        in_sel_a    = '0;
        out_ready_a = 4'hF;
        mode_b      = 1'b0;
        in_valid_b  = 1'b0;
        in_data_b   = '0;
        in_last_b   = 1'b0;
        in_sel_b    = '0;
        out_ready_b = 3'h7;

        #3;
        checkOutput("reset_out_valid", {28'd0, out_valid_a}, 32'd0);
        checkOutput("reset_out_data", out_data_a, 32'd0);
        checkOutput("reset_out_last", {28'd0, out_last_a}, 32'd0);
        checkOutput("reset_in_ready", {31'd0, in_ready_a}, 32'd0);
        checkOutput("reset_rr_ptr", {30'd0, rr_ptr_a}, 32'd0);
        checkOutput("reset_drop_err", {31'd0, drop_err_a}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] test 1: single-beat packets, explicit select");
        for (int k = 0; k < 4; k++) begin
            s = 2'(k);
            d = 8'(8'hA0 + k);
            applyStimulus(0, s, d, 1'b1, k);
        end
        idleInput(0);

        $display("[TB] test 2: 3-beat packet locked to channel 2");
        applyStimulus(0, 2'd2, 8'h11, 1'b0, 2);
        applyStimulus(0, 2'd1, 8'h22, 1'b0, 2);
        applyStimulus(0, 2'd1, 8'h33, 1'b1, 2);
        applyStimulus(0, 2'd0, 8'h44, 1'b1, 0);
        idleInput(0);

        $display("[TB] test 3: backpressure on channel 1");
        out_ready_a = 4'b1101;
        applyStimulus(0, 2'd1, 8'h01, 1'b1, 1);
        fork
            applyStimulus(0, 2'd1, 8'h02, 1'b1, 1);
            begin
                repeat (3) @(negedge clk);
                checkOutput("stall_in_ready", {31'd0, in_ready_a}, 32'd0);
                checkOutput("stall_out_valid1", {31'd0, out_valid_a[1]}, 32'd1);
                checkOutput("stall_out_data1", {24'd0, out_data_a[15:8]}, 32'h01);
                checkOutput("stall_out_last1", {31'd0, out_last_a[1]}, 32'd1);
                @(posedge clk);
                #1;
                out_ready_a = 4'hF;
            end
        join
        idleInput(0);

        $display("[TB] test 4: round-robin with wrap");
        mode_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("rr_ptr_pkt%0d", i), {30'd0, rr_ptr_a}, 32'(i % 4));
            s = 2'(3 - i);
            d = 8'(8'hB0 + 2 * i);
            applyStimulus(0, s, d, 1'b0, i % 4);
            if (i == 1) mode_a = 1'b0;
            d = 8'(8'hB1 + 2 * i);
            applyStimulus(0, s, d, 1'b1, i % 4);
            if (i == 1) mode_a = 1'b1;
        end
        idleInput(0);
        mode_a = 1'b0;
        checkOutput("rr_ptr_after_wrap", {30'd0, rr_ptr_a}, 32'd1);

        $display("[TB] test 5: illegal select on 3-channel instance");
        applyStimulus(1, 2'd3, 8'h55, 1'b0, -1);
        applyStimulus(1, 2'd3, 8'h66, 1'b1, -1);
        applyStimulus(1, 2'd0, 8'h77, 1'b1, 0);
        idleInput(1);
        repeat (2) @(negedge clk);
        checkOutput("drop_pulses", 32'(seen_drops), 32'd2);
        @(posedge clk);
        #1;

        $display("[TB] test 6: reset mid-packet");
        out_ready_a = 4'b1011;
        applyStimulus(0, 2'd2, 8'hD0, 1'b0, -2);
        idleInput(0);
        @(negedge clk);
        checkOutput("pre_reset_valid2", {31'd0, out_valid_a[2]}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_out_valid", {28'd0, out_valid_a}, 32'd0);
        checkOutput("async_in_ready", {31'd0, in_ready_a}, 32'd0);
        checkOutput("async_rr_ptr", {30'd0, rr_ptr_a}, 32'd0);
        @(negedge clk);
        rst_n       = 1'b1;
        out_ready_a = 4'hF;
        @(posedge clk);
        #1;
        applyStimulus(0, 2'd1, 8'hE1, 1'b1, 1);
        idleInput(0);

        waited = 0;
        while (sb.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_demux_1ton.md
Name: stream_demux_1toN

Overview:
- Parametrised, registered 1:N stream demultiplexer with valid/ready handshake and packet-locked routing.
- Next generation of the team's combinational 1:4 demux: generic width and channel count, per-channel output registers, backpressure, and explicit-select or round-robin routing modes.
- Sits between a single upstream stream source and N downstream consumers.

Parameters:
- DATA_W, 8, data beat width in bits.
- NUM_OUT, 4, number of output channels (2..16).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_OUT.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = explicit select, 1 = round-robin per packet.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  upstream beat accepted when in_valid && in_ready.
- in_data  in  DATA_W  beat payload.
- in_last  in  1  final beat of packet.
- in_sel  in  SEL_W  destination channel; used only in mode 0, on the first beat of a packet.
- out_valid  out  NUM_OUT  per-channel valid.
- out_ready  in  NUM_OUT  per-channel consumer ready.
- out_data  out  NUM_OUT*DATA_W  channel k at bits [k*DATA_W +: DATA_W].
- out_last  out  NUM_OUT  per-channel last flag.
- drop_err  out  1  one-cycle pulse per dropped beat.
- rr_ptr  out  SEL_W  current round-robin pointer (debug).

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_last=0, drop_err=0, rr_ptr=0, FSM=IDLE, channel registers empty.
- in_ready is 0 during reset.
- Each channel has a single-entry output register.
  - Accepted beat appears on its channel one cycle later (latency 1).
  - Register is "free" when it is empty, or when out_valid[k] && out_ready[k] in the same cycle.
  - This gives full throughput of 1 beat/cycle per channel.
- FSM with two states:
  - IDLE: no packet in progress.
    - Destination is in_sel in mode 0, or rr_ptr in mode 1.
    - `mode` is sampled only in IDLE.
  - LOCKED: destination is held in an internal dest register until the last beat is accepted.
  - IDLE -> LOCKED: first beat accepted with in_last=0.
  - IDLE -> IDLE: single-beat packet (first beat has in_last=1).
  - LOCKED -> IDLE: beat accepted with in_last=1.
- in_ready = destination register free (combinational from out_ready). No other channel's state affects it.
- Round-robin:
  - rr_ptr increments when the last beat of a packet is accepted in mode 1.
  - It wraps from NUM_OUT-1 to 0.
  - It does not advance in mode 0.
- Illegal select (mode 0, in_sel >= NUM_OUT on the first beat):
  - The packet is dropped: in_ready=1 for all its beats, and no channel is written.
  - drop_err pulses high the cycle after each dropped beat.
  - The FSM tracks in_last normally.
- in_sel changes while LOCKED are ignored.
- in_valid=0 mid-packet: the FSM holds LOCKED indefinitely.
- Output register while out_ready[k]=0: out_data, out_last and out_valid are held stable (AXI-stream rules).
- Simultaneous drain and fill on the same channel: the new beat replaces the old one; out_valid stays 1.
- Reset mid-packet: all in-flight beats are discarded and the FSM returns to IDLE.

Test Plan:
1. Mode 0, NUM_OUT=4, all out_ready=1; send 1-beat packets 0xA0..0xA3 with in_sel=0..3 -> each data appears on channel 0..3 one cycle after acceptance with out_last=1; other out_valid bits stay 0.
2. Mode 0, 3-beat packet 0x11,0x22,0x33 with in_sel=2 on beat 1 and in_sel=1 on beats 2-3 -> all three beats appear on channel 2; FSM returns to IDLE after 0x33.
3. Backpressure: out_ready[1]=0, send two beats to channel 1 -> first is registered, in_ready=0 on the second; raise out_ready[1] -> 0x01 drains, then 0x02 is accepted next cycle; no data is lost or duplicated.
4. Mode 1, four 2-beat packets -> routed to channels 0,1,2,3; fifth packet goes to channel 0 (wrap); rr_ptr reads 0,1,2,3,0.
5. NUM_OUT=3, mode 0, in_sel=3, 2-beat packet -> in_ready=1, both beats dropped, drop_err pulses twice, no out_valid asserted; next packet with in_sel=0 routes normally.
6. Deassert rst_n mid-packet with channel 2 holding valid data -> out_valid=0 immediately (async), FSM=IDLE, rr_ptr=0; after release a new packet routes per in_sel.
